// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU/load results onto one register-file write port and tracks pending registers
// Ports:
//   clk, rst                         clock and asynchronous active-high reset
//   issue_valid, issue_rd            marks issue_rd as pending (busy) at the next edge
//   alu_valid/alu_ready/alu_rd/alu_value      ALU result handshake
//   load_valid/load_ready/load_rd/load_value  load result handshake
//   out_write_enable/number/value    registered register-file write, one cycle after acceptance
//   busy                             bit n set = register n has a result pending
module writeback_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_value,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_rd,
    input  logic [31:0] load_value,
    output logic        out_write_enable,
    output logic [4:0]  out_write_number,
    output logic [31:0] out_write_value,
    output logic [31:0] busy
);
    // last_q: 1 = LOAD won the last contention, 0 = ALU
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [4:0]  num_q, num_d;
    logic [31:0] val_q, val_d;
    logic [31:0] busy_q, busy_d;
    logic        acc;
    logic [4:0]  wr_rd;
    logic [31:0] wr_val;

    // On contention the producer that did not win last time is granted
    assign alu_ready  = !rst && alu_valid && (!load_valid || last_q);
    assign load_ready = !rst && load_valid && (!alu_valid || !last_q);
    assign acc        = alu_ready || load_ready;
    assign wr_rd      = load_ready ? load_rd : alu_rd;
    assign wr_val     = load_ready ? load_value : alu_value;

    always_comb begin
        last_d = (alu_valid && load_valid) ? load_ready : last_q;
        we_d   = acc && (wr_rd != 5'd0);
        num_d  = acc ? wr_rd : num_q;
        val_d  = acc ? wr_val : val_q;
        busy_d = busy_q;
        if (we_d) busy_d[wr_rd] = 1'b0;
        // Issue set is applied after the write clear so it wins on a collision
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
            we_q   <= 1'b0;
            num_q  <= 5'd0;
            val_q  <= 32'd0;
            busy_q <= 32'd0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            num_q  <= num_d;
            val_q  <= val_d;
            busy_q <= busy_d;
        end
    end

    assign out_write_enable = we_q;
    assign out_write_number = num_q;
    assign out_write_value  = val_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard-based self-checking bench for writeback_unit
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        alu_valid = 1'b0, alu_ready;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_value = 32'd0;
    logic        load_valid = 1'b0, load_ready;
    logic [4:0]  load_rd = 5'd0;
    logic [31:0] load_value = 32'd0;
    logic        out_write_enable;
    logic [4:0]  out_write_number;
    logic [31:0] out_write_value;
    logic [31:0] busy;

    typedef struct packed {
        logic        we;
        logic [4:0]  num;
        logic [31:0] val;
    } wr_t;

    wr_t         sb_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        m_last = 1'b0;
    logic [31:0] m_busy = 32'd0;
    logic [4:0]  m_num = 5'd0;
    logic [31:0] m_val = 32'd0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
        .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd), .load_value(load_value),
        .out_write_enable(out_write_enable), .out_write_number(out_write_number),
        .out_write_value(out_write_value), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drives one cycle of stimulus (called just after a falling edge), checks the
    // readies against the model, pushes the expected write and checks it after the edge.
    task automatic step(input logic iv, input logic [4:0] ird,
                        input logic av, input logic [4:0] ard, input logic [31:0] aval,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lval);
        logic ea, el;
        wr_t  e, g;
        issue_valid = iv; issue_rd = ird;
        alu_valid = av; alu_rd = ard; alu_value = aval;
        load_valid = lv; load_rd = lrd; load_value = lval;
        #1;
        ea = av && (!lv || m_last);
        el = lv && (!av || !m_last);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
        chk("load_ready", {31'd0, load_ready}, {31'd0, el});
        if (av && lv) m_last = el;
        e.we = 1'b0;
        if (ea || el) begin
            m_num = el ? lrd : ard;
            m_val = el ? lval : aval;
            e.we = (m_num != 5'd0);
            if (e.we) m_busy[m_num] = 1'b0;
        end
        if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
        e.num = m_num;
        e.val = m_val;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk("out_write_enable", {31'd0, out_write_enable}, {31'd0, g.we});
        chk("out_write_number", {27'd0, out_write_number}, {27'd0, g.num});
        chk("out_write_value", out_write_value, g.val);
        chk("busy", busy, m_busy);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_last = 1'b0;
        m_busy = 32'd0;
        m_num = 5'd0;
        m_val = 32'd0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_we", {31'd0, out_write_enable}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_val", out_write_value, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // Issue then ALU writeback of r5
        step(1, 5'd5, 0, 0, 0, 0, 0, 0);
        chk("busy5_set", {31'd0, busy[5]}, 32'd1);
        step(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("r5_value", out_write_value, 32'hDEADBEEF);
        // Contention alternation: LOAD, ALU, LOAD, ALU
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 5'd1, 32'hA000_0000 + i, 1, 5'd2, 32'hB000_0000 + i);
        // rd 0 load: handshake but no write
        step(0, 0, 0, 0, 0, 1, 5'd0, 32'h1234);
        chk("rd0_no_we", {31'd0, out_write_enable}, 32'd0);
        // Idle cycle holds number/value
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Issue set wins over same-cycle write clear
        step(1, 5'd7, 0, 0, 0, 0, 0, 0);
        step(1, 5'd7, 1, 5'd7, 32'h7777_0007, 0, 0, 0);
        chk("busy7_kept", {31'd0, busy[7]}, 32'd1);
        // Write to a register that is not busy
        step(0, 0, 1, 5'd9, 32'h0909_0909, 0, 0, 0);
        // Build busy = 0xF0 and a pending write, then async reset mid-cycle
        step(1, 5'd4, 0, 0, 0, 0, 0, 0);
        step(1, 5'd5, 0, 0, 0, 0, 0, 0);
        step(1, 5'd6, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5'd1, 32'h1111_1111, 0, 0, 0);
        chk("pre_rst_busy", busy, 32'h0000_00F0);
        chk("pre_rst_we", {31'd0, out_write_enable}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'h3333_3333;
        load_valid = 1'b1; load_rd = 5'd4; load_value = 32'h4444_4444;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_we", {31'd0, out_write_enable}, 32'd0);
        chk("arst_num", {27'd0, out_write_number}, 32'd0);
        chk("arst_val", out_write_value, 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("arst_load_ready", {31'd0, load_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_we", {31'd0, out_write_enable}, 32'd0);
        chk("rst_hold_ready", {30'd0, alu_ready, load_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // ALU alone 3 times (first acceptance right after reset), then contention -> LOAD
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 5'd3, 32'hC000_0000 + i, 0, 0, 0);
        step(0, 0, 1, 5'd3, 32'hC000_0003, 1, 5'd3, 32'hD000_0003);
        chk("contend_load_wins", out_write_value, 32'hD000_0003);
        // Random traffic against the model
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits, register number width at 5 bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port issue_valid  input  1  an instruction with destination issue_rd was issued this cycle.
REQ-006 Port issue_rd  input  5  destination register of the issued instruction.
REQ-007 Port alu_valid  input  1  ALU result offered.
REQ-008 Port alu_ready  output  1  ALU result accepted this cycle.
REQ-009 Port alu_rd  input  5  ALU destination register.
REQ-010 Port alu_value  input  32  ALU result.
REQ-011 Port load_valid  input  1  load result offered.
REQ-012 Port load_ready  output  1  load result accepted this cycle.
REQ-013 Port load_rd  input  5  load destination register.
REQ-014 Port load_value  input  32  load result.
REQ-015 Port out_write_enable  output  1  register-file write strobe, registered.
REQ-016 Port out_write_number  output  5  register-file write index, registered.
REQ-017 Port out_write_value  output  32  register-file write data, registered.
REQ-018 Port busy  output  32  scoreboard; bit n set = register n has a result pending.

Function
REQ-019 At most one producer SHALL be accepted per cycle; accept = valid & ready; ready is combinational from valid inputs and arbiter state, never from out_* outputs.
REQ-020 Arbiter SHALL hold one state bit last_winner in {LOAD, ALU}; only one valid -> that producer is accepted.
REQ-021 Both valid -> producer that is not last_winner SHALL be accepted (alternation on contention).
REQ-022 last_winner SHALL update only on cycles with contention (both valid); single-producer cycles leave it unchanged.
REQ-023 An accepted result SHALL appear on out_write_* exactly one cycle after acceptance (latency 1).
REQ-024 Cycle with no acceptance -> out_write_enable SHALL be 0 next cycle; out_write_number/value SHALL hold previous values.
REQ-025 Accepted result with rd == 0 SHALL complete the handshake but produce out_write_enable = 0 next cycle (number/value still load).
REQ-026 Acceptance of rd != 0 SHALL clear busy[rd] at the same edge that raises out_write_enable.
REQ-027 issue_valid with issue_rd != 0 SHALL set busy[issue_rd] at the next edge.
REQ-028 Same-cycle issue set and write clear of the same register SHALL leave the bit set (set wins).
REQ-029 busy[0] SHALL be constantly 0; issue_rd == 0 SHALL have no effect.
REQ-030 Acceptance for a register whose busy bit is already 0 SHALL still write normally; busy unchanged.
REQ-031 Both producers targeting the same rd SHALL be serialized by the arbiter; no data merging.

Reset
REQ-032 rst asserted SHALL immediately force out_write_enable = 0, out_write_number = 0, out_write_value = 0, busy = 0, last_winner = ALU (so LOAD wins first contention).
REQ-033 While rst is 1, alu_ready and load_ready SHALL be 0.
REQ-034 A result presented during reset or in the same cycle as rst assertion SHALL be dropped; no write after deassertion.
REQ-035 First acceptance SHALL be possible in the first clock edge after rst deasserts.

Verification
REQ-036 Issue rd=5, then ALU rd=5 value 0xDEADBEEF -> busy[5]=1 after issue; alu_ready=1 on offer; next cycle out_write_enable=1, number=5, value=0xDEADBEEF, busy[5]=0.
REQ-037 ALU and load valid for 4 consecutive cycles after reset (rd 1 and 2) -> grant order LOAD, ALU, LOAD, ALU; writes to 2,1,2,1 each one cycle later.
REQ-038 Load rd=0 value 0x1234 -> load_ready=1; next cycle out_write_enable=0; busy stays 0.
REQ-039 issue_valid rd=7 in same cycle as ALU write to rd=7 with busy[7]=1 -> busy[7]=1 after the edge; write still emitted.
REQ-040 Assert rst asynchronously mid-cycle with out_write_enable=1 and busy=0x0000_00F0 -> outputs and busy 0 before next clock edge; ready signals 0 until rst drops.
REQ-041 Only ALU valid for 3 cycles, then both valid -> ALU accepted 3 times, contention grant goes to LOAD (last_winner unchanged by single-producer cycles).
